// File: rtl/mix_lane_serializer.sv
// Bundle-to-stream serializer: takes LANES words in one handshake, emits them one per beat,
// and folds every consumed word into a rotate/xor signature while counting finished bundles.
module mix_lane_serializer #(
    parameter int W       = 32,
    parameter int LANES   = 8,
    parameter int SIG_ROT = 5,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IDX_W-1:0]   out_lane,
    output logic               out_last,
    output logic [W-1:0]       sig,
    output logic [CNT_W-1:0]   bundle_cnt,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                    r_state, w_state_nxt;
    logic [LANES-1:0][W-1:0]   r_buf;
    logic [IDX_W-1:0]          r_idx;
    logic [W-1:0]              r_sig;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_last;
    logic                      w_take;
    logic                      w_load;
    logic [W-1:0]              w_sig_nxt;

    // Handshake decode depends only on state, idx and out_ready, never on in_data.
    always_comb begin
        w_last      = (r_idx == IDX_W'(LANES - 1));
        w_take      = (r_state == SHIFT) && out_ready;
        in_ready    = (r_state == IDLE) || (w_take && w_last);
        w_load      = in_valid && in_ready;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_take && w_last) w_state_nxt = in_valid ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_valid  = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign out_data   = r_buf[r_idx];
    assign out_lane   = r_idx;
    assign out_last   = w_last;
    assign sig        = r_sig;
    assign bundle_cnt = r_cnt;
    assign w_sig_nxt  = {r_sig[W-SIG_ROT-1:0], r_sig[W-1:W-SIG_ROT]} ^ out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_idx   <= '0;
            r_sig   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_buf <= in_data;
                r_idx <= '0;
            end else if (w_take) begin
                // Wraps to 0 after the last lane since LANES is a power of two.
                r_idx <= r_idx + 1'b1;
            end
            if (w_take) begin
                r_sig <= w_sig_nxt;
                if (w_last) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mix_lane_serializer.sv
// Bench for mix_lane_serializer: scoreboard of expected lane words plus a signature/count model,
// a table of single-bundle vectors, and hand-written backpressure/back-to-back/reset/wrap sequences.
module tb_mix_lane_serializer;

    localparam int W = 32, LANES = 8, SIG_ROT = 5, CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [LANES*W-1:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [W-1:0]       out_data;
    logic [2:0]         out_lane;
    logic               out_last;
    logic [W-1:0]       sig;
    logic [CNT_W-1:0]   bundle_cnt;
    logic               busy;

    mix_lane_serializer #(.W(W), .LANES(LANES), .SIG_ROT(SIG_ROT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .out_last(out_last), .sig(sig), .bundle_cnt(bundle_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   lane;
        logic         last;
    } exp_t;

    typedef struct {
        logic [LANES*W-1:0] data;
        logic [W-1:0]       exp_sig;
    } vec_t;

    exp_t             q[$];
    logic [W-1:0]     m_sig = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    int               n_vec = 0;
    int               n_err = 0;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
        return (v << SIG_ROT) | (v >> (W - SIG_ROT));
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and signature/count model, evaluated when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_sig = '0;
            m_cnt = '0;
        end else begin
            chk("sig", sig, m_sig);
            chk("bundle_cnt", W'(bundle_cnt), W'(m_cnt));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_lane", W'(out_lane), W'(e.lane));
                    chk("out_last", W'(out_last), W'(e.last));
                    m_sig = rotl(m_sig) ^ e.d;
                    if (e.last) m_cnt = m_cnt + 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < LANES; k++) begin
                    exp_t e;
                    e.d    = in_data[k*W +: W];
                    e.lane = 3'(k);
                    e.last = (k == LANES - 1);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bundle(input logic [LANES*W-1:0] d);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [LANES*W-1:0] mk(input logic [W-1:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [LANES*W-1:0] b;
        tbl[0] = '{mk(0, 1, 2, 3, 4, 5, 6, 7), 32'h443214C7};
        tbl[1] = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 32'h00000008};
        tbl[2] = '{{LANES{32'hFFFFFFFF}}, 32'h00000000};
        tbl[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5), 32'hA5A5A5A5};
        tbl[4] = '{mk(32'h80000000, 0, 0, 0, 0, 0, 0, 0), 32'h00000004};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_busy", W'(busy), 0);
        chk("rst_sig", sig, 0);
        chk("rst_cnt", W'(bundle_cnt), 0);

        // Single bundles from reset with known signatures
        foreach (tbl[i]) begin
            do_reset();
            send_bundle(tbl[i].data);
            @(negedge clk);
            chk("lat_lane0_valid", W'(out_valid), 1);
            chk("lat_lane0_idx", W'(out_lane), 0);
            wait_idle();
            chk("tbl_sig", sig, tbl[i].exp_sig);
            chk("tbl_cnt", W'(bundle_cnt), 1);
        end

        // Backpressure on lane 2
        do_reset();
        send_bundle(mk(32'h11, 32'h22, 32'hDEADBEEF, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88));
        tick();
        tick();
        out_ready = 1'b0;
        in_data = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_data", out_data, 32'hDEADBEEF);
            chk("bp_lane", W'(out_lane), 2);
            chk("bp_valid", W'(out_valid), 1);
            chk("bp_in_ready", W'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk("bp_cnt", W'(bundle_cnt), 1);

        // Back-to-back bundles with in_valid held high
        do_reset();
        in_valid = 1'b1;
        in_data = mk(1, 2, 3, 4, 5, 6, 7, 8);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            chk("b2b_in_ready", W'(in_ready), W'(c == 0 || c == 8 || c == 16));
            chk("b2b_out_valid", W'(out_valid), W'(c != 0));
            if (c != 0) chk("b2b_lane", W'(out_lane), W'((c - 1) % 8));
            tick();
            if (c == 0) in_data = mk(9, 10, 11, 12, 13, 14, 15, 16);
            if (c == 8) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_busy", W'(busy), 0);
        chk("b2b_cnt", W'(bundle_cnt), 2);

        // Reset while lane 4 is shown
        do_reset();
        send_bundle(mk(10, 11, 12, 13, 14, 15, 16, 17));
        repeat (4) tick();
        @(negedge clk);
        chk("mid_lane", W'(out_lane), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", W'(out_valid), 0);
        chk("mid_in_ready", W'(in_ready), 1);
        chk("mid_sig", sig, 0);
        chk("mid_cnt", W'(bundle_cnt), 0);
        send_bundle(mk(20, 21, 22, 23, 24, 25, 26, 27));
        @(negedge clk);
        chk("mid_restart_lane", W'(out_lane), 0);
        chk("mid_restart_data", out_data, 20);
        wait_idle();

        // Reset coinciding with the last beat
        do_reset();
        send_bundle(mk(1, 2, 3, 4, 5, 6, 7, 8));
        repeat (7) tick();
        @(negedge clk);
        chk("rl_last", W'(out_last), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rl_cnt", W'(bundle_cnt), 0);
        chk("rl_sig", sig, 0);

        // Counter wrap: 16 bundles with a 4-bit counter, some random stalls
        do_reset();
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < LANES; k++) b[k*W +: W] = $urandom;
            send_bundle(b);
            if (n % 4 == 1) begin
                out_ready = 1'b0;
                tick();
                out_ready = 1'b1;
            end
        end
        wait_idle();
        chk("wrap_cnt", W'(bundle_cnt), 0);
        chk("sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
